seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 65536: clk cycles per digit slot (>=2).
REQ-003 SHALL have parameter BLINK_DIV, default 25: blink phase toggles every 2^BLINK_DIV clk cycles.
REQ-004 SHALL have port clk  input  1: single system clock, all state on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port nums  input  4*DIGITS: one nibble per digit; nums[3:0] is digit 0 (rightmost).
REQ-007 SHALL have port load  input  1: one-cycle strobe that captures nums, dp_in and blink_en into shadow registers.
REQ-008 SHALL have port dp_in  input  DIGITS: decimal-point request per digit, 1 = lit.
REQ-009 SHALL have port blink_en  input  DIGITS: per-digit blink enable.
REQ-010 SHALL have port lz_blank  input  1: leading-zero blanking enable (level, sampled live).
REQ-011 SHALL have port display  output  7: registered segments g..a, active-low.
REQ-012 SHALL have port dp  output  1: registered decimal point, active-low.
REQ-013 SHALL have port digit  output  DIGITS: registered one-cold digit enable, active-low.
REQ-014 SHALL have port frame  output  1: registered one-cycle pulse each time the active set is committed.

Function
REQ-015 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; internal tick asserted when count = SCAN_DIV-1.
REQ-016 Scan index SHALL advance 0,1,..,DIGITS-1,0 on each tick; digit, display, dp SHALL reflect the new index in the cycle after the tick (1-cycle latency).
REQ-017 digit SHALL have exactly one 0 bit, at position index, at all times after the first tick.
REQ-018 load SHALL copy nums/dp_in/blink_en into shadow registers; repeated loads before commit: last one wins.
REQ-019 Active registers SHALL take the shadow contents only on a tick with index = DIGITS-1 (frame boundary) and only if a load occurred since the last commit; frame SHALL pulse on that commit.
REQ-020 load coincident with a frame-boundary tick SHALL commit the value being loaded in that same cycle (bypass).
REQ-021 Decode: 0-9 standard active-low codes (0 = 1000000, 8 = 0000000), 10 = 0111111 ('-'), 11-15 = 1111111 (blank).
REQ-022 With lz_blank = 1, digit k (k >= 1) SHALL be blank when its value and all more-significant values are 0; digit 0 SHALL never be leading-zero blanked.
REQ-023 Blink counter SHALL be free-running, BLINK_DIV+1 bits; phase = MSB; when phase = 1 and active blink bit of the scanned digit = 1, display SHALL be 1111111 and dp = 1.
REQ-024 A blanked digit SHALL keep its digit enable low (timing unchanged); only segments and dp go high.
REQ-025 dp SHALL be low when the active dp bit of the scanned digit = 1 and the digit is not blink-blanked; leading-zero blanking SHALL NOT suppress dp.

Reset
REQ-026 On rst: prescaler, index, blink counter = 0; shadow and active registers = 0; pending flag = 0.
REQ-027 On rst: display = 1111111, dp = 1, digit = all ones, frame = 0; outputs hold until first tick.
REQ-028 rst asserted mid-frame SHALL immediately force REQ-027 values regardless of clk; a pending load is discarded.

Verification (DIGITS=4, SCAN_DIV=4, BLINK_DIV=3)
REQ-029 Release rst, nums = 0x1234 loaded at cycle 0 -> digit 1110 after first tick with display = blank code? no: first commit at end of frame 0, thereafter digit 1110/1101/1011/0111 show 4,3,2,1 every 4 cycles; frame pulses once.
REQ-030 Load 0x0050 with lz_blank = 1 -> digits 3,2 blank (1111111), digit 1 shows 5, digit 0 shows 0; with lz_blank = 0 all four show.
REQ-031 Load 0x1111 mid-frame then 0x2222 two cycles later -> no change until frame boundary, then 2222 shown; never 1111; frame pulses once.
REQ-032 blink_en = 0001, dp_in = 0001 -> digit 0 segments and dp alternate lit/blank every 8 cycles; digits 1-3 steady; digit enables unaffected.
REQ-033 Load pulse on the exact frame-boundary tick -> new value shown from next slot; assert rst during slot 2 -> outputs 1111111 / 1 / 1111 same cycle, index restarts at 0.
REQ-034 Load 0xABCF -> digit 3 shows 1111111? No: nibble A shows '-' (0111111), B, C, F show blank.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller.
// Drives DIGITS common-cathode/anode positions one slot at a time. Shadow
// registers take new content on load; that content moves to the active set
// only at a frame boundary, so a frame is never shown half-updated.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   nums[4*DIGITS-1:0]  - one nibble per digit, digit 0 in nums[3:0]
//   load                - strobe capturing nums/dp_in/blink_en into shadow
//   dp_in, blink_en     - per-digit decimal point / blink enable
//   lz_blank            - leading-zero blanking enable (live level)
//   display[6:0]        - segments g..a, active-low, registered
//   dp                  - decimal point, active-low, registered
//   digit[DIGITS-1:0]   - one-cold digit enable, active-low, registered
//   frame               - one-cycle pulse when the active set is committed
module seg_scan_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 65536,
  parameter int unsigned BLINK_DIV = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   nums,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic                  lz_blank,
  output logic [6:0]            display,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit,
  output logic                  frame
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BW = BLINK_DIV + 1;
  localparam int unsigned NW = 4 * DIGITS;

  logic [CW-1:0]     cnt_q,       cnt_d;
  logic [IW-1:0]     idx_q,       idx_d;
  logic [BW-1:0]     blink_q,     blink_d;
  logic              started_q,   started_d;
  logic              pend_q,      pend_d;
  logic [NW-1:0]     sh_nums_q,   sh_nums_d;
  logic [DIGITS-1:0] sh_dp_q,     sh_dp_d;
  logic [DIGITS-1:0] sh_blink_q,  sh_blink_d;
  logic [NW-1:0]     act_nums_q,  act_nums_d;
  logic [DIGITS-1:0] act_dp_q,    act_dp_d;
  logic [DIGITS-1:0] act_blink_q, act_blink_d;
  logic [6:0]        display_q,   display_d;
  logic              dp_q,        dp_d;
  logic [DIGITS-1:0] digit_q,     digit_d;
  logic              frame_q,     frame_d;

  logic              tick_c;
  logic              commit_c;
  logic [3:0]        nib_c;
  logic              lz_c;
  logic              blink_c;
  logic [6:0]        seg_c;

  // Active-low g..a segment code for one nibble.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd10:   s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // True when the selected nibble and every more-significant nibble are zero.
  function automatic logic upper_zero(input logic [NW-1:0] n, input logic [IW-1:0] sel);
    logic r;
    r = 1'b1;
    for (int j = 0; j < int'(DIGITS); j++) begin
      if (j >= int'(sel) && n[j*4 +: 4] != 4'd0) r = 1'b0;
    end
    return r;
  endfunction

  // Next-state and output computation; outputs follow the post-edge state.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    blink_d     = blink_q + BW'(1);
    started_d   = started_q;
    pend_d      = pend_q;
    sh_nums_d   = sh_nums_q;
    sh_dp_d     = sh_dp_q;
    sh_blink_d  = sh_blink_q;
    act_nums_d  = act_nums_q;
    act_dp_d    = act_dp_q;
    act_blink_d = act_blink_q;
    display_d   = display_q;
    dp_d        = dp_q;
    digit_d     = digit_q;

    tick_c = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d  = tick_c ? '0 : cnt_q + CW'(1);

    if (tick_c) begin
      idx_d     = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      started_d = 1'b1;
    end

    if (load) begin
      sh_nums_d  = nums;
      sh_dp_d    = dp_in;
      sh_blink_d = blink_en;
      pend_d     = 1'b1;
    end

    // A load in the boundary cycle itself counts as pending (bypass).
    commit_c = tick_c && (idx_q == IW'(DIGITS - 1)) && (pend_q || load);
    if (commit_c) begin
      act_nums_d  = sh_nums_d;
      act_dp_d    = sh_dp_d;
      act_blink_d = sh_blink_d;
      pend_d      = 1'b0;
    end
    frame_d = commit_c;

    nib_c   = act_nums_d[{idx_d, 2'b00} +: 4];
    lz_c    = lz_blank && (idx_d != '0) && upper_zero(act_nums_d, idx_d);
    blink_c = blink_d[BW-1] && act_blink_d[idx_d];
    seg_c   = (lz_c || blink_c) ? 7'h7F : seg7(nib_c);

    // Outputs stay at their reset values until the first tick.
    if (started_d) begin
      display_d = seg_c;
      dp_d      = ~(act_dp_d[idx_d] && !blink_c);
      digit_d   = ~(DIGITS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      blink_q     <= '0;
      started_q   <= 1'b0;
      pend_q      <= 1'b0;
      sh_nums_q   <= '0;
      sh_dp_q     <= '0;
      sh_blink_q  <= '0;
      act_nums_q  <= '0;
      act_dp_q    <= '0;
      act_blink_q <= '0;
      display_q   <= 7'h7F;
      dp_q        <= 1'b1;
      digit_q     <= '1;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      blink_q     <= blink_d;
      started_q   <= started_d;
      pend_q      <= pend_d;
      sh_nums_q   <= sh_nums_d;
      sh_dp_q     <= sh_dp_d;
      sh_blink_q  <= sh_blink_d;
      act_nums_q  <= act_nums_d;
      act_dp_q    <= act_dp_d;
      act_blink_q <= act_blink_d;
      display_q   <= display_d;
      dp_q        <= dp_d;
      digit_q     <= digit_d;
      frame_q     <= frame_d;
    end
  end

  assign display = display_q;
  assign dp      = dp_q;
  assign digit   = digit_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=4,
// BLINK_DIV=3). The reference derives slot, blink phase and frame boundaries
// from the number of clock edges since reset using plain arithmetic.
module tb_seg_scan_ctrl;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 3;
  localparam int unsigned FRAME_LEN = DIGITS * SCAN_DIV;
  localparam int unsigned N_CYC     = 900;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] nums;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  blink_en;
  logic        lz_blank;
  logic [6:0]  display;
  logic        dp;
  logic [3:0]  digit;
  logic        frame;

  int n_cmp = 0;
  int n_err = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .nums(nums), .load(load), .dp_in(dp_in),
    .blink_en(blink_en), .lz_blank(lz_blank), .display(display),
    .dp(dp), .digit(digit), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference state
  int          e;
  logic [15:0] m_sh_n, m_act_n;
  logic [3:0]  m_sh_dp, m_act_dp, m_sh_bl, m_act_bl;
  bit          m_pend;
  logic [6:0]  x_disp;
  logic        x_dp, x_frame;
  logic [3:0]  x_dig;

  task automatic model_reset();
    e = 0; m_pend = 0;
    m_sh_n = '0; m_act_n = '0; m_sh_dp = '0; m_act_dp = '0; m_sh_bl = '0; m_act_bl = '0;
    x_disp = 7'h7F; x_dp = 1'b1; x_dig = 4'hF; x_frame = 1'b0;
  endtask

  // Advance the reference by one clock edge using the inputs present before it.
  task automatic model_step();
    int k, upper;
    bit lzb, blk;
    e++;
    if (load) begin
      m_sh_n = nums; m_sh_dp = dp_in; m_sh_bl = blink_en; m_pend = 1;
    end
    x_frame = 1'b0;
    if (e % FRAME_LEN == 0 && m_pend) begin
      m_act_n = m_sh_n; m_act_dp = m_sh_dp; m_act_bl = m_sh_bl; m_pend = 0;
      x_frame = 1'b1;
    end
    if (e >= int'(SCAN_DIV)) begin
      k     = (e / SCAN_DIV) % DIGITS;
      upper = int'(m_act_n) >> (4 * k);
      lzb   = lz_blank && k >= 1 && upper == 0;
      blk   = ((e >> BLINK_DIV) & 1) == 1 && m_act_bl[k];
      x_disp = (lzb || blk) ? 7'h7F : ref_seg(upper & 15);
      x_dp   = !(m_act_dp[k] && !blk);
      x_dig  = 4'hF & ~(4'h1 << k);
    end
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_display"}, 32'(display), 32'(x_disp));
    check({pfx, "_dp"},      32'(dp),      32'(x_dp));
    check({pfx, "_digit"},   32'(digit),   32'(x_dig));
    check({pfx, "_frame"},   32'(frame),   32'(x_frame));
  endtask

  logic [15:0] dir_tab [4];
  int          dir_i;

  function automatic logic [15:0] rand_nums();
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    dir_tab[0] = 16'h1234; dir_tab[1] = 16'h0050;
    dir_tab[2] = 16'hABCF; dir_tab[3] = 16'h0000;
    dir_i = 0;
    rst = 1'b1; nums = '0; load = 1'b0; dp_in = '0; blink_en = '0; lz_blank = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < int'(N_CYC); i++) begin
      load = 1'b0;
      // Boundary-coincident loads are forced periodically; others are random.
      if ((e + 1) % FRAME_LEN == 0 && i % 3 == 0) load = 1'b1;
      else if ($urandom_range(0, 5) == 0) load = 1'b1;
      if (load) begin
        nums     = (dir_i < 4) ? dir_tab[dir_i] : rand_nums();
        dir_i++;
        dp_in    = 4'($urandom_range(0, 15));
        blink_en = 4'($urandom_range(0, 15));
      end else begin
        nums = 16'($urandom_range(0, 65535));
      end
      if ($urandom_range(0, 19) == 0) lz_blank = ~lz_blank;

      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs("run");

      // Asynchronous reset mid-frame: outputs must drop before the next edge.
      if (i == 301 || i == 617) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        check_outputs("in_rst");
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
